axi4lite_req_arbiter: RTL and testbench
=======================================

// Module: axi4lite_req_arbiter
// PURPOSE
//  Shares one AXI4-Lite master port between N_REQ simple register-access requesters
//  (CPU bridge, DMA descriptor loader, debug UART, ...). Each request becomes one
//  AXI4-Lite single-beat transaction. Sits between the requesters and the 32-bit
//  register-file slave. One transaction outstanding at a time; round-robin arbitration.
// PARAMETERS
//  N_REQ  4  number of requesters (2..8)
//  AW     8  AXI byte-address width (same as the slave's AW)
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  reset      in   1          synchronous, active-high
//  req_valid  in   N_REQ      request pending, held until req_ready
//  req_ready  out  N_REQ      one-hot accept pulse, 1 cycle
//  req_write  in   N_REQ      1=write, 0=read
//  req_addr   in   N_REQ*AW   byte address per requester (slice i*AW+:AW)
//  req_wdata  in   N_REQ*32   write data per requester
//  req_wstrb  in   N_REQ*4    byte strobes per requester
//  rsp_valid  out  N_REQ      one-hot completion pulse, 1 cycle
//  rsp_rdata  out  32         read data, valid with rsp_valid (0 for writes)
//  rsp_resp   out  2          bresp/rresp of the completed transaction
//  m_awaddr/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready,
//  m_bresp/m_bvalid/m_bready, m_araddr/m_arvalid/m_arready,
//  m_rdata/m_rresp/m_rvalid/m_rready   AXI4-Lite master, standard directions/widths
// BEHAVIOUR
//  Reset: FSM=IDLE, rr_ptr=0, every AXI valid/ready output 0, req_ready=0, rsp_valid=0,
//   rsp_rdata=0, rsp_resp=0. Reset mid-transaction abandons it silently (no rsp_valid).
//  FSM: IDLE -> WR | RD -> BWAIT | RWAIT -> DONE -> IDLE.
//  IDLE: if any req_valid, grant g = first set bit searching from rr_ptr upward (wrapping
//   at N_REQ); pulse req_ready[g]; latch addr/wdata/wstrb/write of g;
//   rr_ptr <= (g+1) mod N_REQ. Next state WR if write else RD. No grant -> stay IDLE.
//  WR: m_awvalid and m_wvalid both asserted the cycle after the grant. Each is held
//   until its own handshake and dropped independently; neither waits on the other's
//   ready. m_awaddr/m_wdata/m_wstrb are stable while their valid is high. Once both
//   handshakes are done -> BWAIT.
//  BWAIT: m_bready=1. On m_bvalid: capture m_bresp -> DONE.
//  RD: m_arvalid=1 with m_araddr held until m_arready -> RWAIT.
//  RWAIT: m_rready=1. On m_rvalid: capture m_rdata and m_rresp -> DONE.
//  DONE: rsp_valid[g]=1 for exactly 1 cycle, with rsp_rdata/rsp_resp -> IDLE.
//   rsp_rdata holds its value until the next DONE.
//  Minimum latency, zero-wait slave: grant at cycle 0, AW/W (or AR) handshake at
//   cycle 1, B/R handshake at cycle 2, rsp_valid at cycle 3. Next grant at cycle 4.
//  req_ready and rsp_valid are never high in the same cycle.
//  Each requester has at most one transaction in flight.
//  A requester that drops req_valid before req_ready is simply not granted.
//  Address bits [1:0] are passed through unchanged; alignment is the slave's concern.
// CONFIGURATION
//  AXIL_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr removed.
//  Not defined (default): round-robin as described above.
// TESTING
//  1 Req0 write addr 0x04, data 0xDEADBEEF, strb 0xF, zero-wait slave ->
//    rsp_valid[0] 3 cycles after req_ready[0]; rsp_resp=0; slave reg1=0xDEADBEEF.
//  2 Req2 read 0x04 after test 1 -> rsp_rdata=0xDEADBEEF, rsp_valid[2] only.
//  3 All 4 requesters hold req_valid continuously, rr_ptr=0 at start ->
//    grant order 0,1,2,3,0. With AXIL_ARB_FIXED_PRIO_EN -> order 0,0,0.
//  4 Slave delays m_awready 3 cycles, m_wready immediate -> m_wvalid drops after
//    1 cycle, m_awvalid held 4 cycles, single B accepted, data written once.
//  5 m_bresp=2'b10 injected -> rsp_resp=2'b10 delivered to the granted requester.
//  6 reset pulsed while in RWAIT -> all outputs return to reset values next cycle,
//    no rsp_valid, next request is granted normally.

Source files
------------

// File: rtl/axi4lite_req_arbiter.sv
// Shares one AXI4-Lite master port among N_REQ register-access requesters, one transaction at a time.
// Round-robin by default; define AXIL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module axi4lite_req_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*32-1:0] req_wdata,
  input  logic [N_REQ*4-1:0]  req_wstrb,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [AW-1:0]       m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [31:0]         m_wdata,
  output logic [3:0]          m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [AW-1:0]       m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [31:0]         m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);

  localparam int          GW = $clog2(N_REQ);
  localparam int unsigned NR = N_REQ;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    BWAIT,
    RWAIT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [GW-1:0]   g_idx;
  logic [AW-1:0]   lat_addr;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_wstrb;
  logic            aw_done;
  logic            w_done;
  logic            aw_ok;
  logic            w_ok;
  logic            any_req;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   scan_idx;
`ifndef AXIL_ARB_FIXED_PRIO_EN
  logic [GW-1:0]   rr_ptr;
`endif

  // First pending requester, scanning upward from the search origin.
  always_comb begin
    any_req  = 1'b0;
    grant    = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NR; k++) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
      scan_idx = GW'(k);
`else
      scan_idx = GW'((32'(rr_ptr) + k) % NR);
`endif
      if (!any_req && req_valid[scan_idx]) begin
        any_req = 1'b1;
        grant   = scan_idx;
      end
    end
  end

  assign m_awvalid = (state == WR) && !aw_done;
  assign m_wvalid  = (state == WR) && !w_done;
  assign m_bready  = (state == BWAIT);
  assign m_arvalid = (state == RD);
  assign m_rready  = (state == RWAIT);
  assign m_awaddr  = lat_addr;
  assign m_araddr  = lat_addr;
  assign m_wdata   = lat_wdata;
  assign m_wstrb   = lat_wstrb;

  // AW and W complete independently; a channel counts as done on its handshake cycle too.
  assign aw_ok = aw_done || (m_awvalid && m_awready);
  assign w_ok  = w_done  || (m_wvalid  && m_wready);

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = req_write[grant] ? WR : RD;
          if (!reset) req_ready[grant] = 1'b1;
        end
      end
      WR:      if (aw_ok && w_ok) state_next = BWAIT;
      BWAIT:   if (m_bvalid)      state_next = DONE;
      RD:      if (m_arready)     state_next = RWAIT;
      RWAIT:   if (m_rvalid)      state_next = DONE;
      DONE: begin
        rsp_valid[g_idx] = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      g_idx     <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (any_req) begin
            g_idx     <= grant;
            lat_addr  <= req_addr[32'(grant)*AW +: AW];
            lat_wdata <= req_wdata[32'(grant)*32 +: 32];
            lat_wstrb <= req_wstrb[32'(grant)*4 +: 4];
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            rr_ptr    <= GW'((32'(grant) + 1) % NR);
`endif
          end
        end
        WR: begin
          if (m_awvalid && m_awready) aw_done <= 1'b1;
          if (m_wvalid && m_wready)   w_done  <= 1'b1;
        end
        BWAIT: begin
          if (m_bvalid) begin
            rsp_rdata <= '0;
            rsp_resp  <= m_bresp;
          end
        end
        RWAIT: begin
          if (m_rvalid) begin
            rsp_rdata <= m_rdata;
            rsp_resp  <= m_rresp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// Scoreboard bench for axi4lite_req_arbiter with a behavioural AXI4-Lite register-file slave.
module tb_axi4lite_req_arbiter;

  localparam int N_REQ = 4;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_write = '0;
  logic [N_REQ*AW-1:0] req_addr  = '0;
  logic [N_REQ*32-1:0] req_wdata = '0;
  logic [N_REQ*4-1:0]  req_wstrb = '0;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_rdata;
  logic [1:0]          rsp_resp;
  logic [AW-1:0]       m_awaddr;
  logic                m_awvalid, m_awready;
  logic [31:0]         m_wdata;
  logic [3:0]          m_wstrb;
  logic                m_wvalid, m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid, m_bready;
  logic [AW-1:0]       m_araddr;
  logic                m_arvalid, m_arready;
  logic [31:0]         m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rvalid, m_rready;

  axi4lite_req_arbiter #(.N_REQ(N_REQ), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [64] = '{default: '0};
  int          aw_delay = 0;
  int          r_delay  = 0;
  logic [1:0]  bresp_inj = 2'b00;
  int          aw_cnt = 0, r_cnt = 0, wcount = 0;
  logic        s_aw_got = 1'b0, s_w_got = 1'b0, s_bvalid = 1'b0, r_pend = 1'b0;
  logic [AW-1:0] s_awaddr = '0;
  logic [31:0] s_wdata = '0, s_rdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        aw_hs, w_hs, have_aw, have_w;
  logic [AW-1:0] eff_addr;
  logic [31:0] eff_data;
  logic [3:0]  eff_strb;

  assign m_awready = (aw_cnt >= aw_delay);
  assign m_wready  = 1'b1;
  assign m_arready = 1'b1;
  assign aw_hs     = m_awvalid & m_awready;
  assign w_hs      = m_wvalid & m_wready;
  assign have_aw   = s_aw_got | aw_hs;
  assign have_w    = s_w_got | w_hs;
  assign eff_addr  = aw_hs ? m_awaddr : s_awaddr;
  assign eff_data  = w_hs ? m_wdata : s_wdata;
  assign eff_strb  = w_hs ? m_wstrb : s_wstrb;
  assign m_bvalid  = s_bvalid;
  assign m_bresp   = bresp_inj;
  assign m_rvalid  = r_pend && (r_cnt >= r_delay);
  assign m_rdata   = s_rdata;
  assign m_rresp   = 2'b00;

  always @(posedge clk) begin
    if (reset) begin
      aw_cnt <= 0; r_cnt <= 0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b0; r_pend <= 1'b0;
    end else begin
      if (aw_hs) aw_cnt <= 0;
      else if (m_awvalid) aw_cnt <= aw_cnt + 1;
      if (have_aw && have_w && !s_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (eff_strb[b]) mem[eff_addr[7:2]][8*b +: 8] <= eff_data[8*b +: 8];
        wcount <= wcount + 1;
        s_bvalid <= 1'b1; s_aw_got <= 1'b0; s_w_got <= 1'b0;
      end else begin
        if (aw_hs) begin s_aw_got <= 1'b1; s_awaddr <= m_awaddr; end
        if (w_hs) begin s_w_got <= 1'b1; s_wdata <= m_wdata; s_wstrb <= m_wstrb; end
      end
      if (s_bvalid && m_bready) s_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        s_rdata <= mem[m_araddr[7:2]]; r_pend <= 1'b1; r_cnt <= 0;
      end else if (r_pend && !m_rvalid) r_cnt <= r_cnt + 1;
      if (m_rvalid && m_rready) r_pend <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } rsp_t;

  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   gq[$];
  rsp_t rq[$];
  int   gtimes[$];
  int   gcyc[N_REQ];
  int   awv_cycles = 0, wv_cycles = 0, b_hs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    int   e;
    rsp_t r;
    forever begin
      @(negedge clk); #3;
      if (m_awvalid) awv_cycles++;
      if (m_wvalid) wv_cycles++;
      if (m_bvalid && m_bready) b_hs++;
      if (req_ready != '0) begin
        if (gq.size() == 0) begin
          tests++; fails++;
          $display("FAIL grant_unexpected: got req_ready=%b expected none", req_ready);
        end else begin
          e = gq.pop_front();
          check32("grant_onehot", 32'(req_ready), 32'(1) << e);
          gcyc[e] = cyc;
          gtimes.push_back(cyc);
        end
      end
      if (rsp_valid != '0) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b expected none", rsp_valid);
        end else begin
          r = rq.pop_front();
          check32("rsp_valid_vec", 32'(rsp_valid), 32'(1) << r.idx);
          check32("rsp_rdata", rsp_rdata, r.rdata);
          check32("rsp_resp", 32'(rsp_resp), 32'(r.resp));
          check32("rsp_excl_ready", 32'(req_ready), 32'd0);
          if (r.lat > 0) check32("rsp_latency", 32'(cyc - gcyc[r.idx]), 32'(r.lat));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_grant(input int i);
    bit got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      #3;
      if (req_ready[i]) got = 1'b1;
      @(negedge clk);
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL grant_timeout: req%0d got no req_ready expected one", i);
    end
  endtask

  task automatic issue(input int i, input bit wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    gq.push_back(i);
    @(negedge clk);
    req_write[i] = wr;
    req_addr[i*AW +: AW] = addr;
    req_wdata[i*32 +: 32] = data;
    req_wstrb[i*4 +: 4] = strb;
    req_valid[i] = 1'b1;
    wait_grant(i);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (rq.size() != 0 || gq.size() != 0); n++) @(negedge clk);
    if (rq.size() != 0 || gq.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d rsp/%0d grants pending expected 0", rq.size(), gq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
  endtask

  initial begin : stim
    int order[$];
    int a0, w0, b0, c0;
    bit got;

    // Reset: request pending during reset must not be accepted.
    req_valid = 4'b0010;
    repeat (3) @(negedge clk);
    #3;
    check32("reset_req_ready", 32'(req_ready), 32'd0);
    check32("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("reset_rsp_rdata", rsp_rdata, 32'd0);
    check32("reset_axi_valids", {27'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 32'd0);
    @(negedge clk);
    req_valid = '0;
    reset = 1'b0;
    @(negedge clk);

    // 1: req0 write 0xDEADBEEF to 0x04.
    rq.push_back(rsp_t'{0, 32'h0, 2'b00, 3});
    issue(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    drain();
    check32("t1_slave_reg1", mem[1], 32'hDEADBEEF);

    // 2: req2 reads it back.
    rq.push_back(rsp_t'{2, 32'hDEADBEEF, 2'b00, 3});
    issue(2, 1'b0, 8'h04, 32'h0, 4'h0);
    drain();

    // 3: all requesters hold reads of 0x04 from a fresh rr_ptr.
    pulse_reset();
`ifdef AXIL_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    gtimes.delete();
    foreach (order[k]) begin
      gq.push_back(order[k]);
      rq.push_back(rsp_t'{order[k], 32'hDEADBEEF, 2'b00, 3});
    end
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      req_write[i] = 1'b0;
      req_addr[i*AW +: AW] = 8'h04;
    end
    req_valid = '1;
    foreach (order[k]) wait_grant(order[k]);
    req_valid = '0;
    drain();
    check32("t3_grant_count", 32'(gtimes.size()), 32'(order.size()));
    for (int k = 0; k + 1 < gtimes.size(); k++)
      check32("t3_grant_spacing", 32'(gtimes[k+1] - gtimes[k]), 32'd4);

    // 4: AW ready delayed 3 cycles, W immediate.
    aw_delay = 3;
    a0 = awv_cycles; w0 = wv_cycles; b0 = b_hs; c0 = wcount;
    rq.push_back(rsp_t'{1, 32'h0, 2'b00, 6});
    issue(1, 1'b1, 8'h08, 32'h12345678, 4'hF);
    drain();
    aw_delay = 0;
    check32("t4_awvalid_cycles", 32'(awv_cycles - a0), 32'd4);
    check32("t4_wvalid_cycles", 32'(wv_cycles - w0), 32'd1);
    check32("t4_b_handshakes", 32'(b_hs - b0), 32'd1);
    check32("t4_slave_writes", 32'(wcount - c0), 32'd1);
    check32("t4_slave_reg2", mem[2], 32'h12345678);

    // 5: SLVERR on B.
    bresp_inj = 2'b10;
    rq.push_back(rsp_t'{3, 32'h0, 2'b10, 3});
    issue(3, 1'b1, 8'h0C, 32'h00000055, 4'hF);
    drain();
    bresp_inj = 2'b00;

    // 6: reset while in RWAIT.
    rq.push_back(rsp_t'{0, 32'hDEADBEEF, 2'b00, 3});
    issue(0, 1'b0, 8'h04, 32'h0, 4'h0);
    drain();
    repeat (3) @(negedge clk);
    #3;
    check32("t6_rdata_hold", rsp_rdata, 32'hDEADBEEF);
    r_delay = 5;
    issue(1, 1'b0, 8'h08, 32'h0, 4'h0);
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      #3;
      if (m_rready) got = 1'b1;
      @(negedge clk);
    end
    check32("t6_reached_rwait", 32'(got), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #3;
    check32("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("t6_rst_rsp_rdata", rsp_rdata, 32'd0);
    check32("t6_rst_rsp_resp", 32'(rsp_resp), 32'd0);
    check32("t6_rst_axi_valids", {27'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 32'd0);
    r_delay = 0;
    repeat (10) @(negedge clk);
    rq.push_back(rsp_t'{2, 32'h0, 2'b00, 3});
    issue(2, 1'b1, 8'h10, 32'hA5A5A5A5, 4'hF);
    drain();
    check32("t6_slave_reg4", mem[4], 32'hA5A5A5A5);

    check32("final_grants_left", 32'(gq.size()), 32'd0);
    check32("final_rsps_left", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
